iack_sequencer: RTL and testbench

//  Prioritises the seven VME IRQ lines and the on-board serial interrupt onto
//  the 68030 IPL pins, then runs each CPU interrupt-acknowledge cycle to

---
 rtl/k30p_pkg.sv | 29 ++
 rtl/irq_priority_encoder.sv | 25 ++
 rtl/iack_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_iack_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/k30p_pkg.sv
// Shared k30p controller definitions: bus polarity, CPU-space function code and
// interrupt-acknowledge sequencer states.
package k30p_pkg;

    localparam logic [2:0] FC_CPU_SPACE = 3'b111;

    // All k30p bus strobes and IRQ lines are active-low.
    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    typedef logic [2:0] iack_state_t;

    localparam iack_state_t IDLE   = 3'd0;
    localparam iack_state_t DECODE = 3'd1;
    localparam iack_state_t S_ACK  = 3'd2;
    localparam iack_state_t V_ACK  = 3'd3;
    localparam iack_state_t AVEC   = 3'd4;
    localparam iack_state_t BERR   = 3'd5;
    localparam iack_state_t DONE   = 3'd6;

    // True when VME IRQ line `lvl` (1-7) is asserted in an active-low vector.
    function automatic logic vme_level_active(input logic [6:0] irq_n, input logic [2:0] lvl);
        if (lvl == 3'd0) begin
            return 1'b0;
        end
        return irq_n[lvl - 3'd1] == ACTIVE;
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational priority encoder: seven synchronised VME IRQs plus the serial
// interrupt to the highest pending level (0 = none).
module irq_priority_encoder
    import k30p_pkg::*;
#(
    parameter int unsigned SERIAL_LEVEL = 5
) (
    input  logic [6:0] vme_irq_n_i,
    input  logic       serial_irq_n_i,
    output logic [2:0] level_o
);

    always_comb begin
        level_o = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (vme_irq_n_i[i] == ACTIVE) begin
                level_o = 3'(i + 1);
            end
        end
        if (serial_irq_n_i == ACTIVE && 3'(SERIAL_LEVEL) > level_o) begin
            level_o = 3'(SERIAL_LEVEL);
        end
    end

endmodule

// File: rtl/iack_sequencer.sv
// Presents pending VME/serial interrupts on the 68030 IPL pins and runs each
// interrupt-acknowledge cycle to a vector, autovector or bus error.
module iack_sequencer
    import k30p_pkg::*;
#(
    parameter int unsigned SERIAL_LEVEL   = 5,
    parameter logic [7:0]  AVEC_MASK      = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] vme_irq,
    input  logic       serial_irq,
    output logic [2:0] cpu_ipl,
    input  logic       cpu_as,
    input  logic [2:0] cpu_fc,
    input  logic [2:0] cpu_addr,
    output logic       vme_iack,
    input  logic       vme_dtack,
    output logic       serial_iack,
    input  logic       serial_dtack,
    output logic       cpu_avec,
    output logic       cpu_berr
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    // Sync bus layout: {serial_dtack, vme_dtack, serial_irq, vme_irq[6:0]}
    logic [9:0] sync1_q, sync2_q;
    logic [6:0] vme_irq_s;
    logic       serial_irq_s, vme_dtack_s, serial_dtack_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {serial_dtack, vme_dtack, serial_irq, vme_irq};
            sync2_q <= sync1_q;
        end
    end

    assign vme_irq_s      = sync2_q[6:0];
    assign serial_irq_s   = sync2_q[7];
    assign vme_dtack_s    = sync2_q[8];
    assign serial_dtack_s = sync2_q[9];

    logic [2:0] level;
    logic [2:0] ipl_q;

    irq_priority_encoder #(
        .SERIAL_LEVEL(SERIAL_LEVEL)
    ) u_encoder (
        .vme_irq_n_i   (vme_irq_s),
        .serial_irq_n_i(serial_irq_s),
        .level_o       (level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ipl_q <= 3'b111;
        end else begin
            ipl_q <= ~level;
        end
    end

    assign cpu_ipl = ipl_q;

    iack_state_t     state_q, state_d;
    logic [2:0]      lvl_q, lvl_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            vme_iack_q, vme_iack_d;
    logic            serial_iack_q, serial_iack_d;
    logic            avec_q, avec_d;
    logic            berr_q, berr_d;
    logic            iack_det;

    assign iack_det = (cpu_as == ACTIVE) && (cpu_fc == FC_CPU_SPACE) && (cpu_addr != 3'd0);

    always_comb begin
        state_d       = state_q;
        lvl_d         = lvl_q;
        cnt_d         = cnt_q;
        vme_iack_d    = vme_iack_q;
        serial_iack_d = serial_iack_q;
        avec_d        = avec_q;
        berr_d        = berr_q;

        // AS negation ends the cycle from any active state, normal or aborted.
        if (state_q != IDLE && cpu_as == INACTIVE) begin
            state_d       = IDLE;
            vme_iack_d    = INACTIVE;
            serial_iack_d = INACTIVE;
            avec_d        = INACTIVE;
            berr_d        = INACTIVE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (iack_det) begin
                        state_d = DECODE;
                        lvl_d   = cpu_addr;
                    end
                end
                DECODE: begin
                    cnt_d = '0;
                    if (serial_irq_s == ACTIVE && lvl_q == 3'(SERIAL_LEVEL)) begin
                        state_d       = S_ACK;
                        serial_iack_d = ACTIVE;
                    end else if (AVEC_MASK[lvl_q]) begin
                        state_d = AVEC;
                        avec_d  = ACTIVE;
                    end else if (vme_level_active(vme_irq_s, lvl_q)) begin
                        state_d    = V_ACK;
                        vme_iack_d = ACTIVE;
                    end else begin
                        state_d = BERR;
                        berr_d  = ACTIVE;
                    end
                end
                S_ACK: begin
                    if (serial_dtack_s == ACTIVE) begin
                        state_d = DONE;
                    end else if (cnt_q == CntLast) begin
                        state_d       = BERR;
                        serial_iack_d = INACTIVE;
                        berr_d        = ACTIVE;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                V_ACK: begin
                    if (vme_dtack_s == ACTIVE) begin
                        state_d = DONE;
                    end else if (cnt_q == CntLast) begin
                        state_d    = BERR;
                        vme_iack_d = INACTIVE;
                        berr_d     = ACTIVE;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                AVEC, BERR: begin
                    state_d = DONE;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d       = IDLE;
                    vme_iack_d    = INACTIVE;
                    serial_iack_d = INACTIVE;
                    avec_d        = INACTIVE;
                    berr_d        = INACTIVE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            lvl_q         <= 3'd0;
            cnt_q         <= '0;
            vme_iack_q    <= INACTIVE;
            serial_iack_q <= INACTIVE;
            avec_q        <= INACTIVE;
            berr_q        <= INACTIVE;
        end else begin
            state_q       <= state_d;
            lvl_q         <= lvl_d;
            cnt_q         <= cnt_d;
            vme_iack_q    <= vme_iack_d;
            serial_iack_q <= serial_iack_d;
            avec_q        <= avec_d;
            berr_q        <= berr_d;
        end
    end

    assign vme_iack    = vme_iack_q;
    assign serial_iack = serial_iack_q;
    assign cpu_avec    = avec_q;
    assign cpu_berr    = berr_q;

endmodule

// File: tb/tb_iack_sequencer.sv
// Directed bench for iack_sequencer with SERIAL_LEVEL=5, AVEC_MASK=8'h80,
// TIMEOUT_CYCLES=64. Strobe vector is {cpu_berr, cpu_avec, serial_iack, vme_iack}.
module tb_iack_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] vme_irq;
    logic       serial_irq;
    logic [2:0] cpu_ipl;
    logic       cpu_as;
    logic [2:0] cpu_fc;
    logic [2:0] cpu_addr;
    logic       vme_iack;
    logic       vme_dtack;
    logic       serial_iack;
    logic       serial_dtack;
    logic       cpu_avec;
    logic       cpu_berr;

    int n_tests = 0;
    int n_fail  = 0;
    int vme_low_cnt = 0;
    int any_low_cnt = 0;
    int multi_cnt   = 0;

    logic [3:0] strobes;
    assign strobes = {cpu_berr, cpu_avec, serial_iack, vme_iack};

    iack_sequencer #(
        .SERIAL_LEVEL  (5),
        .AVEC_MASK     (8'h80),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vme_irq     (vme_irq),
        .serial_irq  (serial_irq),
        .cpu_ipl     (cpu_ipl),
        .cpu_as      (cpu_as),
        .cpu_fc      (cpu_fc),
        .cpu_addr    (cpu_addr),
        .vme_iack    (vme_iack),
        .vme_dtack   (vme_dtack),
        .serial_iack (serial_iack),
        .serial_dtack(serial_dtack),
        .cpu_avec    (cpu_avec),
        .cpu_berr    (cpu_berr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vme_iack == 1'b0) vme_low_cnt++;
        if (strobes != 4'hF) any_low_cnt++;
        if ($countones(~strobes) > 1) multi_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_iack(input logic [2:0] fc, input logic [2:0] addr);
        cpu_fc   = fc;
        cpu_addr = addr;
        cpu_as   = 1'b0;
    endtask

    task automatic end_iack();
        cpu_as   = 1'b1;
        cpu_fc   = 3'b000;
        cpu_addr = 3'b000;
    endtask

    initial begin
        int v0;
        int a0;
        reset        = 1'b0;
        vme_irq      = 7'h7F;
        serial_irq   = 1'b1;
        cpu_as       = 1'b1;
        cpu_fc       = 3'b000;
        cpu_addr     = 3'b000;
        vme_dtack    = 1'b1;
        serial_dtack = 1'b1;
        step(3);
        check("reset_ipl", cpu_ipl, 3'b111);
        check("reset_strobes", strobes, 4'hF);
        reset = 1'b1;
        step(2);

        // 1: IRQ3 vectored acknowledge
        vme_irq = 7'b1111011;
        step(2);
        check("t1_ipl_early", cpu_ipl, 3'b111);
        step(1);
        check("t1_ipl", cpu_ipl, 3'b100);
        start_iack(3'b111, 3'd3);
        step(1);
        check("t1_decode", strobes, 4'hF);
        step(1);
        check("t1_vack", strobes, 4'b1110);
        vme_dtack = 1'b0;
        step(6);
        check("t1_done_hold", strobes, 4'b1110);
        end_iack();
        step(1);
        check("t1_release", strobes, 4'hF);
        vme_dtack = 1'b1;
        vme_irq   = 7'h7F;
        step(3);
        check("t1_ipl_clear", cpu_ipl, 3'b111);

        // 2: serial beats VME at the same level
        serial_irq = 1'b0;
        vme_irq    = 7'b1101111;
        step(3);
        check("t2_ipl", cpu_ipl, 3'b010);
        start_iack(3'b111, 3'd5);
        step(2);
        check("t2_sack", strobes, 4'b1101);
        serial_dtack = 1'b0;
        step(4);
        check("t2_done_hold", strobes, 4'b1101);
        end_iack();
        step(1);
        check("t2_release", strobes, 4'hF);
        serial_dtack = 1'b1;
        serial_irq   = 1'b1;
        vme_irq      = 7'h7F;
        step(3);

        // 3: autovectored IRQ7
        vme_irq = 7'b0111111;
        step(3);
        check("t3_ipl", cpu_ipl, 3'b000);
        v0 = vme_low_cnt;
        start_iack(3'b111, 3'd7);
        step(1);
        check("t3_decode", strobes, 4'hF);
        step(1);
        check("t3_avec", strobes, 4'b1011);
        step(3);
        check("t3_avec_hold", strobes, 4'b1011);
        end_iack();
        step(1);
        check("t3_release", strobes, 4'hF);
        check("t3_no_vme_iack", vme_low_cnt - v0, 0);
        vme_irq = 7'h7F;
        step(3);

        // 4: IRQ2 with no DTACK times out into BERR
        vme_irq = 7'b1111101;
        step(3);
        check("t4_ipl", cpu_ipl, 3'b101);
        v0 = vme_low_cnt;
        start_iack(3'b111, 3'd2);
        step(2);
        check("t4_vack", strobes, 4'b1110);
        step(63);
        check("t4_vack_last", strobes, 4'b1110);
        step(1);
        check("t4_timeout_berr", strobes, 4'b0111);
        check("t4_vack_len", vme_low_cnt - v0, 64);
        step(5);
        check("t4_berr_hold", strobes, 4'b0111);
        end_iack();
        step(1);
        check("t4_release", strobes, 4'hF);
        vme_irq = 7'h7F;
        step(3);

        // 5: spurious level, then a non-CPU-space cycle
        start_iack(3'b111, 3'd4);
        step(2);
        check("t5_spurious", strobes, 4'b0111);
        end_iack();
        step(1);
        check("t5_release", strobes, 4'hF);
        vme_irq = 7'b1111011;
        step(3);
        a0 = any_low_cnt;
        start_iack(3'b101, 3'd3);
        step(10);
        check("t5_fc101_none", any_low_cnt - a0, 0);
        end_iack();
        step(2);

        // 6: abort mid-V_ACK, then async reset mid-S_ACK
        start_iack(3'b111, 3'd3);
        step(2);
        check("t6_vack", strobes, 4'b1110);
        step(5);
        end_iack();
        step(1);
        check("t6_abort_release", strobes, 4'hF);
        step(2);
        start_iack(3'b111, 3'd4);
        step(2);
        check("t6_idle_after_abort", strobes, 4'b0111);
        end_iack();
        step(1);
        vme_irq    = 7'h7F;
        serial_irq = 1'b0;
        step(3);
        start_iack(3'b111, 3'd5);
        step(2);
        check("t6_sack", strobes, 4'b1101);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_strobes", strobes, 4'hF);
        check("t6_async_ipl", cpu_ipl, 3'b111);
        end_iack();
        serial_irq = 1'b1;
        step(2);
        reset = 1'b1;
        step(2);
        check("one_strobe_only", multi_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
